// File: rtl/spi_master_burst.sv
// SPI mode-0 master with register write and N-word burst read.
//
// Ports:
//   clk_i, rst_ni          system clock, asynchronous active-low reset
//   start_i                single-cycle request, honoured only in idle
//   instr_i, addr_i        command byte and register address
//   wr_en_i, wr_data_i     write mode and its payload word
//   rd_len_i               words to read after the address when not writing
//   miso_i                 serial data from the slave
//   cs_o, sclk_o, mosi_o   SPI bus (cs active low, sclk idles low, MSB first)
//   busy_o, done_o         transaction in flight / one-cycle end pulse
//   rx_data_o, rx_valid_o  last completed read word and its update strobe
//
// Build option: define SPI_LOOPBACK_EN to sample mosi instead of miso_i (self-test).
module spi_master_burst #(
    parameter int unsigned ClkDivHalf = 1221,
    parameter int unsigned DataW      = 8,
    parameter int unsigned CntW       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [7:0]       instr_i,
    input  logic [7:0]       addr_i,
    input  logic             wr_en_i,
    input  logic [DataW-1:0] wr_data_i,
    input  logic [CntW-1:0]  rd_len_i,
    input  logic             miso_i,
    output logic             cs_o,
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [DataW-1:0] rx_data_o,
    output logic             rx_valid_o
);

    localparam int unsigned DivW    = (ClkDivHalf > 2) ? $clog2(ClkDivHalf) : 1;
    localparam int unsigned TxW     = 16 + DataW;
    localparam int unsigned MaxBits = 16 + DataW * ((2 ** CntW) - 1);
    localparam int unsigned BitW    = $clog2(MaxBits + 1);
    localparam int unsigned WbitW   = (DataW > 1) ? $clog2(DataW) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e           state_q;
    logic [DivW-1:0]  div_q;
    logic [TxW-1:0]   tx_q;
    logic [BitW-1:0]  bit_q;
    logic [BitW-1:0]  frame_bits_q;
    logic [WbitW-1:0] wbit_q;
    logic [DataW-1:0] rx_sh_q;
    logic [DataW-1:0] rx_data_q;
    logic             wr_en_q;
    logic             cs_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             busy_q;
    logic             done_q;
    logic             rx_valid_q;

    logic             tick;
    logic             read_phase;
    logic             miso_s;
    logic [BitW-1:0]  frame_bits_d;
    logic [DataW-1:0] rx_word;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign miso_s      = mosi_q;
`else
    assign miso_s      = miso_i;
`endif

    assign tick       = (div_q == DivW'(ClkDivHalf - 1));
    // bit_q counts completed bits, so it is the index of the bit now on the wire.
    assign read_phase = !wr_en_q && (bit_q >= BitW'(16));
    assign rx_word    = {rx_sh_q[DataW-2:0], miso_s};

    always_comb begin
        frame_bits_d = BitW'(16 + DataW);
        if (!wr_en_i) begin
            frame_bits_d = BitW'(16 + DataW * rd_len_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            div_q        <= '0;
            tx_q         <= '0;
            bit_q        <= '0;
            frame_bits_q <= '0;
            wbit_q       <= '0;
            rx_sh_q      <= '0;
            rx_data_q    <= '0;
            wr_en_q      <= 1'b0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            // Every state change happens on a tick, so the wrap also clears the
            // divider on entry to the next state.
            if (state_q == StIdle || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DivW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        tx_q         <= {instr_i, addr_i, (wr_en_i ? wr_data_i : {DataW{1'b0}})};
                        frame_bits_q <= frame_bits_d;
                        wr_en_q      <= wr_en_i;
                        bit_q        <= '0;
                        wbit_q       <= '0;
                        cs_q         <= 1'b0;
                        mosi_q       <= instr_i[7];
                        busy_q       <= 1'b1;
                        state_q      <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (read_phase) begin
                                rx_sh_q <= rx_word;
                                if (wbit_q == WbitW'(DataW - 1)) begin
                                    wbit_q     <= '0;
                                    rx_data_q  <= rx_word;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    wbit_q <= wbit_q + WbitW'(1);
                                end
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + BitW'(1);
                            // Zeros shift in behind the payload, so mosi is low
                            // for the whole read phase.
                            tx_q   <= tx_q << 1;
                            if (bit_q + BitW'(1) == frame_bits_q) begin
                                mosi_q  <= 1'b0;
                                state_q <= StHold;
                            end else begin
                                mosi_q <= tx_q[TxW-2];
                            end
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        cs_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cs_o       = cs_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst with a half period of 4 clocks.
module tb_spi_master_burst;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] instr   = 8'h00;
    logic [7:0] addr    = 8'h00;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] rd_len  = 4'h0;
    logic       miso    = 1'b0;
    logic       cs, sclk, mosi, busy, done, rx_valid;
    logic [7:0] rx_data;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef SPI_LOOPBACK_EN
    localparam bit Loop = 1'b1;
`else
    localparam bit Loop = 1'b0;
`endif

    spi_master_burst #(.ClkDivHalf(4), .DataW(8), .CntW(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .instr_i    (instr),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_len_i   (rd_len),
        .miso_i     (miso),
        .cs_o       (cs),
        .sclk_o     (sclk),
        .mosi_o     (mosi),
        .busy_o     (busy),
        .done_o     (done),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid)
    );

    always #5 clk = ~clk;

    // Bus monitor and slave model, all sampled on the falling clock edge.
    int          sclk_rises  = 0;
    int          done_cnt    = 0;
    int          rxv_cnt     = 0;
    int          cs_low_cyc  = 0;
    int          cs_rise_cnt = 0;
    logic [63:0] mosi_cap    = '0;
    logic [63:0] miso_sh     = '0;
    logic [63:0] slave_resp  = '0;
    logic        prev_sclk   = 1'b0;
    logic        prev_cs     = 1'b1;
    logic [7:0]  rx_log  [0:63];
    int          rx_sclk [0:63];

    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            sclk_rises = sclk_rises + 1;
            mosi_cap   = {mosi_cap[62:0], mosi};
        end
        if (!sclk && prev_sclk) begin
            miso    = miso_sh[63];
            miso_sh = miso_sh << 1;
        end
        if (!cs && prev_cs) begin
            miso    = slave_resp[63];
            miso_sh = slave_resp << 1;
        end
        if (cs && !prev_cs) cs_rise_cnt = cs_rise_cnt + 1;
        if (!cs) cs_low_cyc = cs_low_cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (rx_valid && rxv_cnt < 64) begin
            rx_log[rxv_cnt]  = rx_data;
            rx_sclk[rxv_cnt] = sclk_rises;
            rxv_cnt          = rxv_cnt + 1;
        end
        prev_sclk = sclk;
        prev_cs   = cs;
    end

    int b_sclk, b_done, b_rxv, b_cslow, b_csrise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_sclk   = sclk_rises;
        b_done   = done_cnt;
        b_rxv    = rxv_cnt;
        b_cslow  = cs_low_cyc;
        b_csrise = cs_rise_cnt;
    endtask

    task automatic do_start(input logic [7:0] i, input logic [7:0] a, input logic we,
                            input logic [7:0] wd, input logic [3:0] rl);
        @(negedge clk);
        instr = i; addr = a; wr_en = we; wr_data = wd; rd_len = rl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input int sclks, input int dones,
                               input int rxvs, input int cslow);
        check({tag, "_sclk_periods"}, 32'(sclk_rises - b_sclk), 32'(sclks));
        check({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'(dones));
        check({tag, "_rx_valid_pulses"}, 32'(rxv_cnt - b_rxv), 32'(rxvs));
        check({tag, "_cs_low_cycles"}, 32'(cs_low_cyc - b_cslow), 32'(cslow));
        check({tag, "_cs_rises"}, 32'(cs_rise_cnt - b_csrise), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs", {31'b0, cs}, 32'd1);
        check("rst_sclk", {31'b0, sclk}, 32'd0);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of the shift phase
        do_start(8'h0B, 8'h08, 1'b0, 8'h00, 4'd1);
        repeat (40) @(negedge clk);
        check("mid_cs_low", {31'b0, cs}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs", {31'b0, cs}, 32'd1);
        check("async_rst_sclk", {31'b0, sclk}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_mosi", {31'b0, mosi}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register read 0x0B/0x08, slave returns 0xA5
        slave_resp = {16'h0000, 8'hA5, 40'h0};
        snap();
        do_start(8'h0B, 8'h08, 1'b0, 8'h00, 4'd1);
        wait_idle("rd1");
        check_frame("rd1", 24, 1, 1, 200);
        check("rd1_mosi_cmd", {16'b0, mosi_cap[23:8]}, 32'h0B08);
        check("rd1_mosi_read_low", {24'b0, mosi_cap[7:0]}, 32'h00);
        check("rd1_rx_word", {24'b0, rx_log[b_rxv]}, Loop ? 32'h00 : 32'hA5);
        check("rd1_rx_at_sclk", 32'(rx_sclk[b_rxv] - b_sclk), 32'd24);
        check("rd1_rx_held", {24'b0, rx_data}, Loop ? 32'h00 : 32'hA5);

        // Command/address only
        snap();
        do_start(8'h0B, 8'h07, 1'b0, 8'h00, 4'd0);
        wait_idle("rd0");
        check_frame("rd0", 16, 1, 0, 136);
        check("rd0_mosi", {16'b0, mosi_cap[15:0]}, 32'h0B07);

        // Write 0x0A/0x2D/0x02; rd_len must be ignored
        snap();
        do_start(8'h0A, 8'h2D, 1'b1, 8'h02, 4'd3);
        wait_idle("wr");
        check_frame("wr", 24, 1, 0, 200);
        check("wr_mosi", {8'b0, mosi_cap[23:0]}, 32'h0A2D02);

        // Burst read of three words
        slave_resp = {16'h0000, 24'h112233, 24'h0};
        snap();
        do_start(8'h0B, 8'h0E, 1'b0, 8'h00, 4'd3);
        wait_idle("burst");
        check_frame("burst", 40, 1, 3, 328);
        check("burst_w0", {24'b0, rx_log[b_rxv]}, Loop ? 32'h00 : 32'h11);
        check("burst_w1", {24'b0, rx_log[b_rxv + 1]}, Loop ? 32'h00 : 32'h22);
        check("burst_w2", {24'b0, rx_log[b_rxv + 2]}, Loop ? 32'h00 : 32'h33);
        check("burst_w0_sclk", 32'(rx_sclk[b_rxv] - b_sclk), 32'd24);
        check("burst_w1_sclk", 32'(rx_sclk[b_rxv + 1] - b_sclk), 32'd32);
        check("burst_w2_sclk", 32'(rx_sclk[b_rxv + 2] - b_sclk), 32'd40);

        // START while busy and inputs changed mid-frame
        snap();
        do_start(8'h0A, 8'h1F, 1'b1, 8'h5A, 4'd0);
        repeat (60) @(negedge clk);
        instr = 8'h0B; addr = 8'h33; wr_en = 1'b0; wr_data = 8'hFF; rd_len = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (30) @(negedge clk);
        check("busy_start_no_queue", {31'b0, busy}, 32'd0);
        check_frame("busy_start", 24, 1, 0, 200);
        check("busy_start_mosi", {8'b0, mosi_cap[23:0]}, 32'h0A1F5A);

        // Read 0x0B/0x09; loopback build sees mosi low in the read phase
        slave_resp = {16'h0000, 8'hC3, 40'h0};
        snap();
        do_start(8'h0B, 8'h09, 1'b0, 8'h00, 4'd1);
        wait_idle("rd2");
        check_frame("rd2", 24, 1, 1, 200);
        check("rd2_rx_word", {24'b0, rx_data}, Loop ? 32'h00 : 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_burst.md
Name: spi_master_burst

Overview:
- Parametrised SPI mode-0 master for the on-board accelerometer (ADXL362-class command set); successor to the fixed 16-bit-command controller.
- Adds a host start/busy/done handshake, register write with data byte, N-byte burst read with per-byte valid strobe, parametrised SCLK divider, and guaranteed CS setup/hold/gap timing.
- Sits between the switch/button decode logic and the 7-segment display path.

Parameters:
CLK_DIV_HALF, 1221, CLK cycles per SCLK half period (1221 at 125 MHz gives about 51 kHz SCLK); minimum 2
DATA_W, 8, width of the write-data and read-data words
CNT_W, 4, width of RD_LEN; maximum burst is 2^CNT_W-1 words

Ports:
CLK  in  1  system clock, 125 MHz
RESETN  in  1  asynchronous active-low reset
START  in  1  single-cycle request; sampled only in IDLE
INSTR  in  8  command byte (0x0B read, 0x0A write, 0x0D FIFO read)
ADDR  in  8  register address
WR_EN  in  1  1 = send WR_DATA after ADDR; RD_LEN is ignored
WR_DATA  in  DATA_W  write payload
RD_LEN  in  CNT_W  number of words to read after ADDR when WR_EN=0; 0 = command/address only
MISO  in  1  serial data from the slave
CS  out  1  chip select, active low
SCLK  out  1  serial clock, idles low
MOSI  out  1  serial data to the slave, MSB first
BUSY  out  1  high from the cycle after an accepted START until return to IDLE
DONE  out  1  one-cycle pulse when CS deasserts at transaction end
RX_DATA  out  DATA_W  last completed read word; held until the next word completes
RX_VALID  out  1  one-cycle pulse when RX_DATA updates

Behaviour:
- Reset, asynchronous, at any time including mid-transfer:
  - CS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, RX_VALID=0.
  - State IDLE; divider, bit and word counters cleared.
- Accepting a request:
  - START in IDLE latches INSTR, ADDR, WR_EN, WR_DATA and RD_LEN.
  - Later changes to these inputs have no effect on the running transaction.
  - START while BUSY is ignored; no queueing.
- Divider:
  - Counts 0..CLK_DIV_HALF-1 in every state except IDLE; the terminal count is a "tick".
  - The divider is cleared on entry to each state.
- States:
  - IDLE -> SETUP on START.
  - SETUP: CS=0, MOSI=INSTR[7]; after 1 tick -> SHIFT.
  - SHIFT: each tick toggles SCLK.
    - Rising edge (SCLK 0->1): sample MISO (read phase only).
    - Falling edge (1->0): drive the next MOSI bit.
  - After the falling edge that ends the last bit -> HOLD, with SCLK low and MOSI=0.
  - HOLD: CS stays 0 for 1 tick, then CS=1 and DONE pulses in the same cycle -> GAP.
  - GAP: CS=1 for 1 tick -> IDLE. BUSY drops on IDLE entry.
- Frame length: 16 + DATA_W*(WR_EN ? 1 : RD_LEN) SCLK periods.
  - Bit order: INSTR[7:0], ADDR[7:0], then WR_DATA MSB first, or the read words.
- Read phase:
  - MOSI=0.
  - MISO is shifted MSB first.
  - On the rising-edge cycle of the last bit of each word: RX_DATA loads the word and RX_VALID pulses in the next cycle.
  - Burst reads continue contiguously with no CS deassertion between words.
- Simultaneous events: START on the same cycle BUSY falls is ignored; START is honoured only when the state is IDLE.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the internal MISO sample source is MOSI (self-test); the external MISO port is ignored.
- Not defined: MISO port sampled as specified above. Port list is identical in both builds.

Test Plan:
1. Reset mid-transfer: assert RESETN=0 during SHIFT -> CS=1, SCLK=0, BUSY=0 within the same cycle (asynchronous); after release the next START runs a clean frame.
2. Register read, CLK_DIV_HALF=4: INSTR=0x0B, ADDR=0x08, RD_LEN=1, slave returns 0xA5 ->
   - MOSI bits 0x0B08 on 16 rising edges; 24 SCLK periods total.
   - One RX_VALID with RX_DATA=0xA5; DONE once; CS low for exactly 24*8+8 CLK cycles.
3. Write: INSTR=0x0A, ADDR=0x2D, WR_EN=1, WR_DATA=0x02 -> MOSI stream 0x0A2D02; no RX_VALID; DONE once.
4. Burst read: RD_LEN=3, slave returns 0x11, 0x22, 0x33 -> three RX_VALID pulses spaced 8 SCLK periods apart with those values; CS never deasserts mid-frame.
5. START asserted while BUSY, and inputs changed mid-frame -> no second transaction; the frame uses the latched values.
6. SPI_LOOPBACK_EN defined, INSTR=0x0B, ADDR=0x09, RD_LEN=1 -> RX_DATA=0x00 (MOSI is low during the read phase).
